inst_queue: RTL and testbench

Dual-lane instruction queue between the fetch stage and the dual-issue decode stage of the compute unit. It accepts up to two instructions per cycle from fetch (a 64-bit bundle split into inst0/inst1 with per-lane valids), buffers them with their PCs, and presents the two oldest entries to decode. Decode consumes 0, 1 or 2 per cycle. The queue also provides the backpressure that drives fetch's stall input and is flushed on any redirect.

---
 rtl/cu_fetch_pkg.sv | 12 +
 rtl/inst_queue_if.sv | 36 +++
 rtl/inst_queue.sv | 114 +++++++++++
 tb/tb_inst_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_fetch_pkg.sv
// Types and constants shared by fetch, the instruction queue and decode.
package cu_fetch_pkg;

    localparam int unsigned INST_BYTES  = 4;
    localparam int unsigned FETCH_LANES = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } inst_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push port and decode-side pop port of the instruction queue.
interface inst_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid0;
    logic            in_valid1;
    logic [31:0]     in_pc;
    logic [31:0]     in_inst0;
    logic [31:0]     in_inst1;
    logic            in_ready;
    logic            out_valid0;
    logic            out_valid1;
    logic [31:0]     out_pc0;
    logic [31:0]     out_pc1;
    logic [31:0]     out_inst0;
    logic [31:0]     out_inst1;
    logic [1:0]      deq_count;
    logic [CntW-1:0] count;

    // master: fetch + decode + redirect source; slave: the queue
    modport master (
        output flush, in_valid0, in_valid1, in_pc, in_inst0, in_inst1, deq_count,
        input  in_ready, out_valid0, out_valid1, out_pc0, out_pc1, out_inst0, out_inst1,
               count
    );

    modport slave (
        input  flush, in_valid0, in_valid1, in_pc, in_inst0, in_inst1, deq_count,
        output in_ready, out_valid0, out_valid1, out_pc0, out_pc1, out_inst0, out_inst1,
               count
    );

endinterface

// File: rtl/inst_queue.sv
// Dual-lane instruction queue: up to two pushes from fetch and up to two pops by decode
// per cycle, with flush on redirect and registered backpressure.
module inst_queue
    import cu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_queue_if.slave  bus
);

    localparam int unsigned     PtrW     = $clog2(DEPTH);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] ReadyMax = CntW'(DEPTH - FETCH_LANES);
    localparam logic [1:0]      MaxPop   = 2'(FETCH_LANES);

    inst_entry_t storage [DEPTH];

    logic [PtrW-1:0] head_q, head_d, head_nxt;
    logic [PtrW-1:0] tail_q, tail_d, tail_nxt;
    logic [CntW-1:0] count_q, count_d;

    logic        ready;
    logic        push0, push1;
    logic [1:0]  push_num, pop_req, pop_num;
    inst_entry_t wr0, wr1, rd0, rd1;

    // Readiness depends only on registered occupancy, never on this cycle's dequeue.
    assign ready    = (count_q <= ReadyMax);
    assign tail_nxt = tail_q + PtrW'(1);
    assign head_nxt = head_q + PtrW'(1);

    always_comb begin
        push0    = ready & bus.in_valid0 & ~bus.flush;
        push1    = push0 & bus.in_valid1;
        push_num = {1'b0, push0} + {1'b0, push1};

        // deq_count=3 behaves as 2; requests beyond occupancy are trimmed
        pop_req = bus.deq_count[1] ? MaxPop : {1'b0, bus.deq_count[0]};
        if (count_q < CntW'(pop_req)) begin
            pop_num = count_q[1:0];
        end else begin
            pop_num = pop_req;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PtrW'(pop_num);
            tail_d  = tail_q + PtrW'(push_num);
            count_d = count_q + CntW'(push_num) - CntW'(pop_num);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        wr0      = '0;
        wr1      = '0;
        wr0.pc   = bus.in_pc;
        wr0.inst = bus.in_inst0;
        wr1.pc   = bus.in_pc + 32'(INST_BYTES);
        wr1.inst = bus.in_inst1;
    end

    // Payload storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push0) begin
            storage[tail_q] <= wr0;
        end
        if (push1) begin
            storage[tail_nxt] <= wr1;
        end
    end

    assign rd0 = storage[head_q];
    assign rd1 = storage[head_nxt];

    always_comb begin
        bus.in_ready   = ready;
        bus.count      = count_q;
        bus.out_valid0 = (count_q != '0);
        bus.out_valid1 = (count_q >= CntW'(2));
        bus.out_pc0    = bus.out_valid0 ? rd0.pc   : '0;
        bus.out_inst0  = bus.out_valid0 ? rd0.inst : '0;
        bus.out_pc1    = bus.out_valid1 ? rd1.pc   : '0;
        bus.out_inst1  = bus.out_valid1 ? rd1.inst : '0;
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CntW'(DEPTH));

    a_ptr_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (tail_q - head_q) == count_q[PtrW-1:0]);

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: expected entries are queued as pushes are accepted and
// compared against the decode-side outputs as they are exposed and consumed.
module tb_inst_queue;
    import cu_fetch_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    inst_queue_if #(.DEPTH(DEPTH)) bus ();

    inst_queue #(.DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    inst_entry_t sb [$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.in_valid0 = 1'b0;
        bus.in_valid1 = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst0  = '0;
        bus.in_inst1  = '0;
        bus.deq_count = '0;
    endtask

    // Applies one cycle of stimulus from a negedge and updates the scoreboard model.
    task automatic drive(input logic v0, input logic v1, input logic [31:0] pc,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] deq, input logic fl);
        bit accept;
        int pop;
        bus.in_valid0 = v0;
        bus.in_valid1 = v1;
        bus.in_pc     = pc;
        bus.in_inst0  = i0;
        bus.in_inst1  = i1;
        bus.deq_count = deq;
        bus.flush     = fl;
        accept = !fl && v0 && (sb.size() <= int'(DEPTH) - 2);
        pop    = (deq == 2'd3) ? 2 : int'(deq);
        if (pop > sb.size()) pop = sb.size();
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            repeat (pop) void'(sb.pop_front());
            if (accept) begin
                sb.push_back('{pc: pc, inst: i0});
                if (v1) sb.push_back('{pc: pc + 32'd4, inst: i1});
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        vectors++;
        if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b%b want 00", bus.out_valid0, bus.out_valid1);
        end
        vectors++;
        if (bus.count !== CW'(0)) begin
            miscompares++; $display("FAIL reset_count: got %0d want 0", bus.count);
        end
        vectors++;
        if (bus.out_pc0 !== 32'h0 || bus.out_inst1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got pc0=%h inst1=%h want 0", bus.out_pc0, bus.out_inst1);
        end
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_basic();
        drive(1, 1, 32'h100, 32'hA, 32'hB, 2'd0, 0);
        vectors++;
        if (bus.out_valid0 !== 1'b1 || bus.out_valid1 !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_valid: got %b%b want 11", bus.out_valid0, bus.out_valid1);
        end
        vectors++;
        if (bus.out_pc0 !== 32'h100 || bus.out_pc1 !== 32'h104) begin
            miscompares++;
            $display("FAIL basic_pc: got %h/%h want 100/104", bus.out_pc0, bus.out_pc1);
        end
        vectors++;
        if (bus.out_inst0 !== 32'hA || bus.out_inst1 !== 32'hB) begin
            miscompares++;
            $display("FAIL basic_inst: got %h/%h want a/b", bus.out_inst0, bus.out_inst1);
        end
        vectors++;
        if (bus.count !== CW'(2)) begin
            miscompares++; $display("FAIL basic_count: got %0d want 2", bus.count);
        end
        drive(0, 0, 0, 0, 0, 2'd2, 0);
        vectors++;
        if (bus.count !== CW'(0) || bus.out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drain: got count=%0d v0=%b want 0/0", bus.count, bus.out_valid0);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h1000 + 32'(16 * k), 32'(2 * k), 32'(2 * k + 1), 2'd0, 0);
        end
        vectors++;
        if (bus.count !== CW'(8) || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got count=%0d rdy=%b want 8/0", bus.count, bus.in_ready);
        end
        drive(1, 1, 32'hDEAD_0000, 32'hDEAD, 32'hBEEF, 2'd0, 0);
        vectors++;
        if (bus.count !== CW'(8)) begin
            miscompares++; $display("FAIL fill_ignored: got %0d want 8", bus.count);
        end
        vectors++;
        if (bus.out_pc0 !== 32'h1000 || bus.out_pc1 !== 32'h1004) begin
            miscompares++;
            $display("FAIL fill_head: got %h/%h want 1000/1004", bus.out_pc0, bus.out_pc1);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        drive(0, 0, 0, 0, 0, 2'd1, 0);
        vectors++;
        if (bus.count !== CW'(7) || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_seven: got count=%0d rdy=%b want 7/0", bus.count, bus.in_ready);
        end
        bus.in_valid0 = 1'b1;
        bus.deq_count = 2'd2;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_ready_same_cycle: got %b want 0", bus.in_ready);
        end
        drive(1, 0, 32'h7777_0000, 32'h77, 0, 2'd2, 0);
        vectors++;
        if (bus.count !== CW'(5)) begin
            miscompares++; $display("FAIL bp_count: got %0d want 5", bus.count);
        end
        vectors++;
        if (bus.out_pc0 !== 32'h1014) begin
            miscompares++; $display("FAIL bp_head: got %h want 1014", bus.out_pc0);
        end
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            guard++;
            vectors++;
            if (bus.out_pc0 !== sb[0].pc || bus.out_inst0 !== sb[0].inst) begin
                miscompares++;
                $display("FAIL bp_drain0: got %h/%h want %h/%h", bus.out_pc0, bus.out_inst0,
                         sb[0].pc, sb[0].inst);
            end
            if (sb.size() >= 2) begin
                vectors++;
                if (bus.out_pc1 !== sb[1].pc || bus.out_inst1 !== sb[1].inst) begin
                    miscompares++;
                    $display("FAIL bp_drain1: got %h/%h want %h/%h", bus.out_pc1, bus.out_inst1,
                             sb[1].pc, sb[1].inst);
                end
            end
            drive(0, 0, 0, 0, 0, 2'd2, 0);
        end
        vectors++;
        if (bus.count !== CW'(0) || guard >= 20) begin
            miscompares++; $display("FAIL bp_empty: got %0d want 0", bus.count);
        end
    endtask

    task automatic test_wrap();
        // Walk head and tail to slot DEPTH-1 before the two-wide push.
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 32'h300 + 32'(4 * k), 32'(k), 0, 2'd1, 0);
        end
        drive(0, 0, 0, 0, 0, 2'd1, 0);
        vectors++;
        if (bus.count !== CW'(0)) begin
            miscompares++; $display("FAIL wrap_setup: got %0d want 0", bus.count);
        end
        drive(1, 1, 32'h200, 32'h20, 32'h21, 2'd0, 0);
        vectors++;
        if (bus.out_pc0 !== 32'h200 || bus.out_pc1 !== 32'h204 || bus.out_inst1 !== 32'h21) begin
            miscompares++;
            $display("FAIL wrap_pair: got %h/%h/%h want 200/204/21", bus.out_pc0, bus.out_pc1,
                     bus.out_inst1);
        end
        drive(0, 0, 0, 0, 0, 2'd1, 0);
        vectors++;
        if (bus.out_pc0 !== 32'h204 || bus.out_valid1 !== 1'b0 || bus.count !== CW'(1)) begin
            miscompares++;
            $display("FAIL wrap_second: got pc=%h v1=%b cnt=%0d want 204/0/1", bus.out_pc0,
                     bus.out_valid1, bus.count);
        end
        drive(0, 0, 0, 0, 0, 2'd1, 0);
        drive(1, 1, 32'hFFFF_FFFC, 32'h31, 32'h32, 2'd0, 0);
        vectors++;
        if (bus.out_pc0 !== 32'hFFFF_FFFC || bus.out_pc1 !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got %h/%h want fffffffc/0", bus.out_pc0, bus.out_pc1);
        end
        drive(0, 0, 0, 0, 0, 2'd2, 0);
        vectors++;
        if (bus.count !== CW'(0)) begin
            miscompares++; $display("FAIL wrap_empty: got %0d want 0", bus.count);
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 32'h400, 1, 2, 2'd0, 0);
        drive(1, 1, 32'h408, 3, 4, 2'd0, 0);
        drive(1, 0, 32'h410, 5, 0, 2'd0, 0);
        vectors++;
        if (bus.count !== CW'(5)) begin
            miscompares++; $display("FAIL flush_setup: got %0d want 5", bus.count);
        end
        drive(1, 1, 32'h480, 8, 9, 2'd2, 1);
        vectors++;
        if (bus.count !== CW'(0) || bus.out_valid0 !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state: got cnt=%0d v0=%b rdy=%b want 0/0/1", bus.count,
                     bus.out_valid0, bus.in_ready);
        end
        drive(1, 0, 32'h500, 32'h50, 0, 2'd0, 0);
        vectors++;
        if (bus.out_pc0 !== 32'h500 || bus.count !== CW'(1)) begin
            miscompares++;
            $display("FAIL flush_refill: got %h/%0d want 500/1", bus.out_pc0, bus.count);
        end
        drive(0, 0, 0, 0, 0, 2'd1, 0);
    endtask

    task automatic test_underflow();
        drive(1, 0, 32'h600, 32'h60, 0, 2'd0, 0);
        drive(0, 0, 0, 0, 0, 2'd2, 0);
        vectors++;
        if (bus.count !== CW'(0) || bus.out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL under_count: got %0d/%b want 0/0", bus.count, bus.out_valid0);
        end
        drive(0, 0, 0, 0, 0, 2'd2, 0);
        drive(1, 1, 32'h700, 32'h70, 32'h71, 2'd0, 0);
        vectors++;
        if (bus.out_pc0 !== 32'h700 || bus.out_pc1 !== 32'h704 || bus.count !== CW'(2)) begin
            miscompares++;
            $display("FAIL under_head: got %h/%h/%0d want 700/704/2", bus.out_pc0, bus.out_pc1,
                     bus.count);
        end
        drive(0, 0, 0, 0, 0, 2'd3, 0);
        vectors++;
        if (bus.count !== CW'(0)) begin
            miscompares++; $display("FAIL deq3: got %0d want 0", bus.count);
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] exp_cnt;
        logic [31:0]   exp_pc0, exp_pc1, exp_i0, exp_i1;
        for (int n = 0; n < 300; n++) begin
            exp_cnt = CW'(sb.size());
            exp_pc0 = (sb.size() >= 1) ? sb[0].pc   : 32'h0;
            exp_i0  = (sb.size() >= 1) ? sb[0].inst : 32'h0;
            exp_pc1 = (sb.size() >= 2) ? sb[1].pc   : 32'h0;
            exp_i1  = (sb.size() >= 2) ? sb[1].inst : 32'h0;
            vectors++;
            if (bus.count !== exp_cnt) begin
                miscompares++; $display("FAIL rnd_count: got %0d want %0d", bus.count, exp_cnt);
            end
            vectors++;
            if (bus.in_ready !== (sb.size() <= int'(DEPTH) - 2)) begin
                miscompares++; $display("FAIL rnd_ready: got %b at count %0d", bus.in_ready,
                                        sb.size());
            end
            vectors++;
            if (bus.out_valid0 !== (sb.size() >= 1) || bus.out_valid1 !== (sb.size() >= 2)) begin
                miscompares++;
                $display("FAIL rnd_valid: got %b%b at count %0d", bus.out_valid0,
                         bus.out_valid1, sb.size());
            end
            vectors++;
            if (bus.out_pc0 !== exp_pc0 || bus.out_inst0 !== exp_i0) begin
                miscompares++;
                $display("FAIL rnd_lane0: got %h/%h want %h/%h", bus.out_pc0, bus.out_inst0,
                         exp_pc0, exp_i0);
            end
            vectors++;
            if (bus.out_pc1 !== exp_pc1 || bus.out_inst1 !== exp_i1) begin
                miscompares++;
                $display("FAIL rnd_lane1: got %h/%h want %h/%h", bus.out_pc1, bus.out_inst1,
                         exp_pc1, exp_i1);
            end
            drive($urandom_range(3) != 0, $urandom_range(1) == 1,
                  {$urandom_range(32'h0FFF_FFFF), 2'b00}, $urandom, $urandom,
                  2'($urandom_range(3)), $urandom_range(31) == 0);
        end
        drive(0, 0, 0, 0, 0, 2'd0, 1);
    endtask

    task automatic test_async_reset();
        drive(1, 1, 32'h900, 32'h90, 32'h91, 2'd0, 0);
        drive(1, 0, 32'h908, 32'h92, 0, 2'd1, 0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.count !== CW'(0) || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_count: got %0d/%b want 0/1", bus.count, bus.in_ready);
        end
        vectors++;
        if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0 || bus.out_pc0 !== 32'h0 ||
            bus.out_inst0 !== 32'h0) begin
            miscompares++;
            $display("FAIL arst_outputs: got v=%b%b pc0=%h i0=%h want 0", bus.out_valid0,
                     bus.out_valid1, bus.out_pc0, bus.out_inst0);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 32'h800, 32'h80, 32'h81, 2'd0, 0);
        vectors++;
        if (bus.out_pc0 !== 32'h800 || bus.out_inst1 !== 32'h81 || bus.count !== CW'(2)) begin
            miscompares++;
            $display("FAIL arst_first_push: got %h/%h/%0d want 800/81/2", bus.out_pc0,
                     bus.out_inst1, bus.count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_backpressure();
        test_wrap();
        test_flush();
        test_underflow();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
